uart_rx: RTL and testbench

- UART serial receiver; the receive-side counterpart of the team's UART transmitter (start/data/optional parity/stop framing, line idles high).
- Sits between the asynchronous RX pin and the parallel-data consumer.
- Oversamples the line, majority-votes each bit, checks parity and stop, and presents one byte per valid frame with a single-cycle strobe.

---
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 3-sample majority vote per bit, optional parity, single-cycle result strobes.
// data_valid is high in the cycle after the 80th CLK edge following the first edge that samples RX_IN low (defaults, no parity).
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s = 0
// START  | qualifying start bit; a majority of 1 is a glitch
// DATA   | shifting data bits in, LSB first
// PARITY | capturing the parity bit
// STOP   | sampling the stop bit and reporting the frame
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [EW-1:0] CNT_LAST = EW'(OVERSAMPLE - 1);
    localparam logic [EW-1:0] CNT_S0   = EW'(M - 1);
    localparam logic [EW-1:0] CNT_S1   = EW'(M);
    localparam logic [EW-1:0] CNT_DEC  = EW'(M + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  rx_par_q, rx_par_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic maj;
    logic cnt_wrap;
    logic decide;
    logic exp_par;
    logic perr;

    // Third vote is the live rx_s on the decision edge.
    assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign cnt_wrap = (edge_cnt_q == CNT_LAST);
    assign decide   = (edge_cnt_q == CNT_DEC);
    assign exp_par  = (^shift_q) ^ par_typ_q;
    assign perr     = par_en_q && (rx_par_q != exp_par);

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        rx_par_d   = rx_par_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (edge_cnt_q == CNT_S0) samp_d[0] = rx_s_q;
        if (edge_cnt_q == CNT_S1) samp_d[1] = rx_s_q;

        if (state_q != IDLE) begin
            edge_cnt_d = cnt_wrap ? '0 : edge_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_s_q) begin
                    state_d   = START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (cnt_wrap) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = maj;
                end
                if (cnt_wrap) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (decide) rx_par_d = maj;
                if (cnt_wrap) state_d = STOP;
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                if (decide) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    se_d       = !maj;
                    pe_d       = perr;
                    if (maj && !perr) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            rx_par_q   <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            rx_meta_q  <= RX_IN;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            rx_par_q   <= rx_par_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected strobes and latency, a negedge monitor pops and compares.
module tb_uart_rx;

    localparam int OS = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;

    uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pdata;
        int         start;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_pdata = 8'h00;
    int         n_checks = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic send_bit(input logic v);
        RX_IN = v;
        repeat (OS) @(negedge CLK);
    endtask

    // Called at a negedge; the next posedge is the first to see the start bit.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic bad_par, input logic stop_v, input int idle_after);
        logic par_bit;
        exp_t e;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        par_bit = (^d) ^ ptyp ^ bad_par;
        e.pe    = pen && bad_par;
        e.se    = !stop_v;
        e.dv    = !e.pe && !e.se;
        if (e.dv) model_pdata = d;
        e.pdata = model_pdata;
        e.start = cyc + 1;
        e.lat   = (9 + (pen ? 1 : 0)) * OS + OS;
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(par_bit);
        send_bit(stop_v);
        RX_IN = 1'b1;
        repeat (idle_after) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (data_valid || par_err || stp_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {29'd0, data_valid, par_err, stp_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_valid", data_valid, e.dv);
                chk("par_err", par_err, e.pe);
                chk("stp_err", stp_err, e.se);
                chk("p_data", P_DATA, e.pdata);
                chk("latency", cyc - e.start, e.lat);
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_p_data", P_DATA, 8'h00);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_pe", par_err, 1'b0);
        chk("rst_se", stp_err, 1'b0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Plain frame, then even-parity good and bad.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 12);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 12);
        send_frame(8'h3D, 1'b1, 1'b0, 1'b1, 1'b1, 12);

        // Framing error, then recovery.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 24);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 12);

        // Start-bit glitch is rejected.
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (24) @(negedge CLK);
        chk("glitch_no_strobe", {data_valid, par_err, stp_err}, 3'b000);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 12);

        // Back-to-back odd-parity frames; PAR_EN/PAR_TYP change mid-frame is ignored.
        fork
            begin
                send_frame(8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 0);
                send_frame(8'h34, 1'b1, 1'b1, 1'b0, 1'b1, 12);
            end
            begin
                repeat (20) @(negedge CLK);
                PAR_EN  = 1'b0;
                PAR_TYP = 1'b0;
            end
        join

        // Reset during the 5th data bit abandons the frame.
        PAR_EN = 1'b0;
        RX_IN  = 1'b0;
        repeat (OS) @(negedge CLK);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        RX_IN = 1'b1;
        repeat (OS / 2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst_p_data", P_DATA, 8'h00);
        chk("midrst_strobes", {data_valid, par_err, stp_err}, 3'b000);
        model_pdata = 8'h00;
        repeat (100) @(negedge CLK);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 20);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
